// File: rtl/latency_mem_model_if.sv
// Request/response bundle between a memory master and latency_mem_model.
// The wmask byte enables exist only when MEM_WMASK_EN is defined.
interface latency_mem_model_if #(
    parameter int LINE_BITS = 256
);
    logic                   read;
    logic                   write;
    logic [31:0]            address;
    logic [LINE_BITS-1:0]   wdata;
`ifdef MEM_WMASK_EN
    logic [LINE_BITS/8-1:0] wmask;
`endif
    logic                   resp;
    logic [LINE_BITS-1:0]   rdata;
    logic                   error;

    modport master (
        output read, write, address, wdata,
`ifdef MEM_WMASK_EN
        output wmask,
`endif
        input  resp, rdata, error
    );

    modport slave (
        input  read, write, address, wdata,
`ifdef MEM_WMASK_EN
        input  wmask,
`endif
        output resp, rdata, error
    );
endinterface

// File: rtl/latency_mem_model.sv
// Line-addressed memory with fixed read/write latency, abort on request drop,
// and error responses. Define MEM_WMASK_EN to enable per-byte write masking.
module latency_mem_model #(
    parameter int LINE_BITS = 256,
    parameter int DEPTH     = 1024,
    parameter int RD_LAT    = 4,
    parameter int WR_LAT    = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    latency_mem_model_if.slave bus
);
    localparam int NBYTES  = LINE_BITS / 8;
    localparam int OFF     = $clog2(NBYTES);
    localparam int IDX_W   = $clog2(DEPTH);
    localparam int TOP     = OFF + IDX_W;
    localparam int MAX_LAT = (RD_LAT > WR_LAT) ? RD_LAT : WR_LAT;
    localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
    localparam logic [31:0] HI_MASK = (TOP >= 32) ? 32'h0 : (32'hFFFF_FFFF << TOP);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_e;

    // OP_BAD marks a read+write collision: no latched request, so it never aborts.
    typedef enum logic [1:0] {
        OP_RD,
        OP_WR,
        OP_BAD
    } op_e;

    state_e               state_q, state_d;
    op_e                  op_q, op_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic                 oor_q, oor_d;
    logic [LINE_BITS-1:0] wdata_q, wdata_d;
`ifdef MEM_WMASK_EN
    logic [NBYTES-1:0]    wmask_q, wmask_d;
`endif

    logic                 req_held;
    logic                 resp_c;
    logic                 error_c;
    logic                 commit_c;
    logic                 rd_en_c;
    logic                 unused_low;

    logic [LINE_BITS-1:0] mem_q [DEPTH];

    assign unused_low = ^bus.address[OFF-1:0];

    assign req_held = (op_q == OP_BAD)
                   || ((op_q == OP_RD) && bus.read)
                   || ((op_q == OP_WR) && bus.write);

    // NOTE: every signal gets its default before the case so no path leaves one unassigned and infers a latch.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        oor_d    = oor_q;
        wdata_d  = wdata_q;
`ifdef MEM_WMASK_EN
        wmask_d  = wmask_q;
`endif
        resp_c   = 1'b0;
        error_c  = 1'b0;
        commit_c = 1'b0;
        rd_en_c  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.read && bus.write) begin
                    op_d    = OP_BAD;
                    cnt_d   = '0;
                    oor_d   = 1'b0;
                    state_d = S_BUSY;
                end else if (bus.read || bus.write) begin
                    op_d    = bus.read ? OP_RD : OP_WR;
                    cnt_d   = bus.read ? CNT_W'(RD_LAT - 1) : CNT_W'(WR_LAT - 1);
                    idx_d   = bus.address[OFF +: IDX_W];
                    oor_d   = |(bus.address & HI_MASK);
                    wdata_d = bus.wdata;
`ifdef MEM_WMASK_EN
                    wmask_d = bus.wmask;
`endif
                    state_d = S_BUSY;
                end
            end

            S_BUSY: begin
                if (!req_held) begin
                    state_d = S_IDLE;
                end else if (cnt_q == '0) begin
                    resp_c   = 1'b1;
                    error_c  = oor_q || (op_q == OP_BAD);
                    commit_c = (op_q == OP_WR) && !oor_q;
                    rd_en_c  = (op_q == OP_RD) && !oor_q;
                    state_d  = S_DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A request caught by reset must neither respond nor touch the array.
        if (!rst_n) begin
            resp_c   = 1'b0;
            error_c  = 1'b0;
            commit_c = 1'b0;
            rd_en_c  = 1'b0;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            op_q    <= OP_RD;
            cnt_q   <= '0;
            idx_q   <= '0;
            oor_q   <= 1'b0;
            wdata_q <= '0;
`ifdef MEM_WMASK_EN
            wmask_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            oor_q   <= oor_d;
            wdata_q <= wdata_d;
`ifdef MEM_WMASK_EN
            wmask_q <= wmask_d;
`endif
        end
    end

    // NOTE: the array has no reset; contents survive rst_n and start undefined.
    always_ff @(posedge clk) begin
        if (commit_c) begin
`ifdef MEM_WMASK_EN
            for (int b = 0; b < NBYTES; b++) begin
                if (wmask_q[b]) begin
                    mem_q[idx_q][b*8 +: 8] <= wdata_q[b*8 +: 8];
                end
            end
`else
            mem_q[idx_q] <= wdata_q;
`endif
        end
    end

    assign bus.resp  = resp_c;
    assign bus.error = error_c;
    assign bus.rdata = rd_en_c ? mem_q[idx_q] : '0;

endmodule

// File: tb/tb_latency_mem_model.sv
// Randomized bench for latency_mem_model against a line-array reference model.
// Compile with MEM_WMASK_EN defined to exercise the byte-mask build.
module tb_latency_mem_model;
    localparam int LINE_BITS = 256;
    localparam int DEPTH     = 1024;
    localparam int RD_LAT    = 4;
    localparam int WR_LAT    = 4;
    localparam int NB        = LINE_BITS / 8;
    localparam int MAX_WAIT  = RD_LAT + WR_LAT + 4;

    typedef logic [LINE_BITS-1:0] line_t;
    typedef logic [NB-1:0]        mask_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    latency_mem_model_if #(.LINE_BITS(LINE_BITS)) bus ();

    latency_mem_model #(
        .LINE_BITS(LINE_BITS),
        .DEPTH    (DEPTH),
        .RD_LAT   (RD_LAT),
        .WR_LAT   (WR_LAT)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int    total = 0;
    int    bad   = 0;
    line_t model_mem [int];

    task automatic check(input string tag, input line_t got, input line_t exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic line_t rand_line();
        line_t l;
        for (int i = 0; i < LINE_BITS / 32; i++) l[i*32 +: 32] = $urandom;
        return l;
    endfunction

    task automatic drive_idle();
        bus.read    = 1'b0;
        bus.write   = 1'b0;
        bus.address = '0;
        bus.wdata   = '0;
`ifdef MEM_WMASK_EN
        bus.wmask   = '0;
`endif
    endtask

    // Called at a negedge; returns at a negedge with the bus idle.
    task automatic run_req(input bit rd, input bit wr, input logic [31:0] addr,
                           input line_t data, input mask_t msk, input int drop_after,
                           input bit scramble, output bit got_resp, output int lat,
                           output line_t rline, output bit gerr);
        bus.read    = rd;
        bus.write   = wr;
        bus.address = addr;
        bus.wdata   = data;
`ifdef MEM_WMASK_EN
        bus.wmask   = msk;
`endif
        got_resp = 1'b0;
        lat      = 0;
        rline    = '0;
        gerr     = 1'b0;
        for (int k = 1; k <= MAX_WAIT && !got_resp; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.resp) begin
                got_resp = 1'b1;
                lat      = k;
                rline    = bus.rdata;
                gerr     = bus.error;
            end else begin
                check("rdata_zero_no_resp", bus.rdata, '0);
                if (k == drop_after) begin
                    bus.read  = 1'b0;
                    bus.write = 1'b0;
                end
                if (scramble) begin
                    bus.address = $urandom;
                    bus.wdata   = rand_line();
                end
            end
        end
        if (got_resp) begin
            // Keep the request up across DONE; it must not be serviced again.
            @(posedge clk);
            @(negedge clk);
            check("done_resp_low", bus.resp, 1'b0);
            @(posedge clk);
            @(negedge clk);
            check("idle_after_done", bus.resp, 1'b0);
        end
        drive_idle();
    endtask

    task automatic do_op(input string tag, input bit rd, input bit wr,
                         input logic [31:0] addr, input line_t data, input mask_t msk,
                         input int drop_after, input bit scramble);
        bit    conflict, oor, got_resp, gerr;
        int    idx, lat, exp_lat;
        line_t rline, exp_line, cur;
        conflict = rd && wr;
        oor      = (longint'(addr) / NB) >= DEPTH;
        idx      = int'((longint'(addr) / NB) % DEPTH);
        exp_lat  = conflict ? 1 : (rd ? RD_LAT : WR_LAT);
        run_req(rd, wr, addr, data, msk, drop_after, scramble, got_resp, lat, rline, gerr);
        if (drop_after > 0) begin
            check({tag, "_aborted_no_resp"}, got_resp, 1'b0);
            return;
        end
        check({tag, "_resp"}, got_resp, 1'b1);
        check({tag, "_latency"}, line_t'(lat), line_t'(exp_lat));
        check({tag, "_error"}, gerr, conflict || oor);
        if (rd && !wr && !oor)
            exp_line = model_mem.exists(idx) ? model_mem[idx] : 'x;
        else
            exp_line = '0;
        check({tag, "_rdata"}, rline, exp_line);
        if (wr && !rd && !oor) begin
            cur = model_mem.exists(idx) ? model_mem[idx] : 'x;
`ifdef MEM_WMASK_EN
            for (int b = 0; b < NB; b++) if (msk[b]) cur[b*8 +: 8] = data[b*8 +: 8];
`else
            cur = data;
`endif
            model_mem[idx] = cur;
        end
    endtask

    initial begin
        line_t       a5_line, ones_line, pattern;
        logic [31:0] addr;
        int          r, idx, drop;
        bit          rd, wr;

        drive_idle();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_resp", bus.resp, 1'b0);
        check("reset_error", bus.error, 1'b0);
        check("reset_rdata", bus.rdata, '0);
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("post_reset_resp", bus.resp, 1'b0);

        for (int i = 0; i < 16; i++)
            do_op("init_wr", 1'b0, 1'b1, 32'(i * NB), rand_line(), '1, -1, 1'b0);

        // Write 0xA5 line to 0x40 and read it back.
        for (int b = 0; b < NB; b++) a5_line[b*8 +: 8] = 8'hA5;
        do_op("a5_wr", 1'b0, 1'b1, 32'h40, a5_line, '1, -1, 1'b0);
        do_op("a5_rd", 1'b1, 1'b0, 32'h40, '0, '0, -1, 1'b0);

        // Read+write collision at 0x0 leaves the line untouched.
        do_op("collide", 1'b1, 1'b1, 32'h0, rand_line(), '1, -1, 1'b0);
        do_op("collide_rd", 1'b1, 1'b0, 32'h0, '0, '0, -1, 1'b0);

        // Out-of-range accesses, including one that would alias line 0x40.
        do_op("oor_rd", 1'b1, 1'b0, 32'h0010_0000, '0, '0, -1, 1'b0);
        do_op("oor_wr", 1'b0, 1'b1, 32'h0010_0040, rand_line(), '1, -1, 1'b0);
        do_op("oor_alias_rd", 1'b1, 1'b0, 32'h40, '0, '0, -1, 1'b0);

        // Write to 0x80 abandoned after two busy cycles.
        do_op("abort_wr", 1'b0, 1'b1, 32'h80, rand_line(), '1, 2, 1'b0);
        do_op("abort_rd", 1'b1, 1'b0, 32'h80, '0, '0, -1, 1'b0);

`ifdef MEM_WMASK_EN
        ones_line = '1;
        do_op("mask_clr", 1'b0, 1'b1, 32'hC0, '0, '1, -1, 1'b0);
        do_op("mask_wr", 1'b0, 1'b1, 32'hC0, ones_line, mask_t'(32'h0000_000F), -1, 1'b0);
        do_op("mask_rd", 1'b1, 1'b0, 32'hC0, '0, '0, -1, 1'b0);
        check("mask_line_c0", model_mem[6], line_t'(32'hFFFF_FFFF));
        do_op("mask_zero_wr", 1'b0, 1'b1, 32'hC0, rand_line(), '0, -1, 1'b0);
        do_op("mask_zero_rd", 1'b1, 1'b0, 32'hC0, '0, '0, -1, 1'b0);
`else
        ones_line = '1;
        do_op("full_wr", 1'b0, 1'b1, 32'hC0, ones_line, '0, -1, 1'b0);
        do_op("full_rd", 1'b1, 1'b0, 32'hC0, '0, '0, -1, 1'b0);
`endif

        // Reset in the middle of a write to 0x100.
        pattern     = rand_line();
        bus.write   = 1'b1;
        bus.address = 32'h100;
        bus.wdata   = pattern;
`ifdef MEM_WMASK_EN
        bus.wmask   = '1;
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        drive_idle();
        for (int k = 0; k < 2; k++) begin
            @(posedge clk);
            @(negedge clk);
            check("rst_mid_resp", bus.resp, 1'b0);
        end
        rst_n = 1'b1;
        for (int k = 0; k < WR_LAT + 2; k++) begin
            @(posedge clk);
            @(negedge clk);
            check("rst_after_resp", bus.resp, 1'b0);
        end
        do_op("rst_rd", 1'b1, 1'b0, 32'h100, '0, '0, -1, 1'b0);

        // Random mix over the 16 initialised lines.
        for (int n = 0; n < 80; n++) begin
            r    = $urandom_range(0, 99);
            idx  = $urandom_range(0, 15);
            addr = 32'(idx * NB) + 32'($urandom_range(0, NB - 1));
            rd   = $urandom_range(0, 1);
            wr   = !rd;
            drop = -1;
            if (r < 8) begin
                rd = 1'b1;
                wr = 1'b1;
            end else if (r < 18) begin
                addr = (32'h8000 << $urandom_range(0, 16)) | 32'($urandom_range(0, 32'h7FFF));
            end else if (r < 28) begin
                drop = $urandom_range(1, (rd ? RD_LAT : WR_LAT) - 1);
            end
            do_op("rand", rd, wr, addr, rand_line(), mask_t'(rand_line()), drop,
                  bit'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
